// File: rtl/if_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_stage_pkg
// Description : Shared constants, FSM state encoding and queue entry type
//               for the instruction-fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package if_stage_pkg;

    // Word handed to decode when nothing valid is queued.
    localparam logic [31:0] INST_NOP_WORD = 32'h0000_0000;

    // Sequential fetch advance, one 32-bit instruction word.
    localparam logic [31:0] PC_STEP = 32'd4;

    // Fetch FSM state encoding.
    localparam int IF_STATE_BUS = 2;

    typedef enum logic [IF_STATE_BUS-1:0] {
        IF_STATE_IDLE    = 2'd0,
        IF_STATE_REQUEST = 2'd1,
        IF_STATE_DISCARD = 2'd2
    } if_state_e;

    // One prefetch queue slot: the fetch address and the word returned for it.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } fetch_entry_t;

    // Force an address onto a 4-byte boundary.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage
`default_nettype wire

// File: rtl/if_stage_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Circular prefetch FIFO of {pc, instruction} entries with a
//               synchronous clear. Push when full and pop when empty are
//               ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
    import if_stage_pkg::*;
#(
    parameter int QUEUE_DEPTH = 2
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           push,
    input  fetch_entry_t                   push_entry,
    input  logic                           pop,
    input  logic                           clear,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(QUEUE_DEPTH):0]   count,
    output fetch_entry_t                   head_entry
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     r_storage [QUEUE_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign full       = (r_count == CNT_W'(QUEUE_DEPTH));
    assign empty      = (r_count == '0);
    assign count      = r_count;
    assign head_entry = r_storage[r_rd_ptr];

    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Pointer and occupancy bookkeeping; power-of-two depth makes wrap free.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; contents need no reset because empty masks the head.
    always_ff @(posedge clock) begin
        if (w_do_push && !clear && !reset) begin
            r_storage[r_wr_ptr] <= push_entry;
        end
    end

endmodule
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_stage
// Description : Instruction-fetch stage. Owns the fetch PC, issues single-beat
//               reads over a request/ready handshake, buffers returned words
//               in a prefetch queue and supports redirect (flush).
// Revision    : 1.0 - initial release
// ============================================================================
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] flush_target,
    output logic        mem_read_enable,
    output logic [31:0] mem_read_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_read_data,
    output logic [31:0] program_counter,
    output logic [31:0] instruction,
    output logic        instruction_valid
);

    localparam int          CNT_W          = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [31:0] RESET_PC_WORD  = align_word(RESET_PC);

    if_state_e    r_state;
    logic [31:0]  r_fetch_pc;
    logic [31:0]  r_flush_target;

    logic         w_push;
    logic         w_pop;
    logic         w_queue_full;
    logic         w_queue_empty;
    logic [CNT_W-1:0] w_count;
    logic [CNT_W:0]   w_count_next;
    logic         w_has_space;
    logic [31:0]  w_target;
    logic [31:0]  w_fetch_pc_inc;
    fetch_entry_t w_push_entry;
    fetch_entry_t w_head_entry;

    // A returned word is kept only on a live (non-discard) request with no
    // redirect in the same cycle; flush also suppresses the pop so that the
    // clear wins cleanly.
    assign w_push = (r_state == IF_STATE_REQUEST) && mem_ready && !flush;
    assign w_pop  = instruction_valid && !stall && !flush;

    // Occupancy after this cycle's push/pop decides whether to keep streaming.
    assign w_count_next = {1'b0, w_count} + (CNT_W+1)'(w_push) - (CNT_W+1)'(w_pop);
    assign w_has_space  = (w_count_next < (CNT_W+1)'(QUEUE_DEPTH));

    assign w_target       = align_word(flush_target);
    assign w_fetch_pc_inc = r_fetch_pc + PC_STEP;

    assign w_push_entry.pc   = mem_read_addr;
    assign w_push_entry.word = mem_read_data;

    fetch_queue #(
        .QUEUE_DEPTH (QUEUE_DEPTH)
    ) u_fetch_queue (
        .clock      (clock),
        .reset      (reset),
        .push       (w_push),
        .push_entry (w_push_entry),
        .pop        (w_pop),
        .clear      (flush),
        .full       (w_queue_full),
        .empty      (w_queue_empty),
        .count      (w_count),
        .head_entry (w_head_entry)
    );

    // Decode sees a NOP at PC 0 whenever nothing is queued.
    assign instruction_valid = !w_queue_empty;
    assign instruction       = w_queue_empty ? INST_NOP_WORD : w_head_entry.word;
    assign program_counter   = w_queue_empty ? 32'h0 : w_head_entry.pc;

    // Fetch FSM: request sequencing, fetch PC advance and redirect handling.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state         <= IF_STATE_IDLE;
            r_fetch_pc      <= RESET_PC_WORD;
            r_flush_target  <= RESET_PC_WORD;
            mem_read_enable <= 1'b0;
            mem_read_addr   <= RESET_PC_WORD;
        end else begin
            case (r_state)
                IF_STATE_IDLE: begin
                    if (flush) begin
                        r_fetch_pc <= w_target;
                    end else if (!w_queue_full) begin
                        r_state         <= IF_STATE_REQUEST;
                        mem_read_enable <= 1'b1;
                        mem_read_addr   <= r_fetch_pc;
                    end
                end

                IF_STATE_REQUEST: begin
                    if (mem_ready) begin
                        if (flush) begin
                            // Word arrives with the redirect: drop it, no
                            // outstanding request remains to discard.
                            r_state         <= IF_STATE_IDLE;
                            mem_read_enable <= 1'b0;
                            r_fetch_pc      <= w_target;
                        end else begin
                            r_fetch_pc <= w_fetch_pc_inc;
                            if (w_has_space) begin
                                mem_read_addr <= w_fetch_pc_inc;
                            end else begin
                                r_state         <= IF_STATE_IDLE;
                                mem_read_enable <= 1'b0;
                            end
                        end
                    end else if (flush) begin
                        // Request cannot be withdrawn; finish it and drop
                        // the data, remembering where to go afterwards.
                        r_state        <= IF_STATE_DISCARD;
                        r_flush_target <= w_target;
                    end
                end

                IF_STATE_DISCARD: begin
                    if (mem_ready) begin
                        r_state         <= IF_STATE_IDLE;
                        mem_read_enable <= 1'b0;
                        r_fetch_pc      <= flush ? w_target : r_flush_target;
                    end else if (flush) begin
                        r_flush_target <= w_target;
                    end
                end

                default: begin
                    r_state         <= IF_STATE_IDLE;
                    mem_read_enable <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
